reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-side tracker for the integer register file: records which destination registers have writes in flight between ID and WB, and retires them when the WB-stage write-back port commits.
- Sits in ID beside the register-file read ports. Raises stall_id when a source operand still has a pending write. Drives pipeline stall and bubble insertion.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked; x0 is never tracked.
- CNT_W, 2, width of the per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- issue_valid  input  1  ID holds a valid instruction.
- issue_wr  input  1  instruction writes a destination register.
- issue_rd  input  5  destination register index.
- rs1_id  input  5  source 1 index.
- rs2_id  input  5  source 2 index.
- rs1_used  input  1  instruction reads rs1.
- rs2_used  input  1  instruction reads rs2.
- regwrite_wb  input  1  WB stage commits a register write.
- dst_wb  input  5  WB destination index.
- flush  input  1  discard all younger in-flight writes (branch redirect).
- stall_id  output  1  hold ID; instruction not accepted this cycle.
- rs1_busy  output  1  rs1 has a pending write.
- rs2_busy  output  1  rs2 has a pending write.
- busy_vec  output  32  bit i = counter i nonzero (registered view).
- wb_underflow  output  1  sticky error: WB retired a register whose counter was 0.

Behaviour:
- Reset (rst=1 at rising edge): all counters 0, busy_vec=0, wb_underflow=0. Combinational outputs follow, so stall_id=0 and rs1_busy/rs2_busy=0. Reset mid-operation discards all pending state.
- Index 0: never counted, never busy, and WB to x0 is ignored. This matches the register file, which drops writes to x0.
- wb_hit(i) = regwrite_wb && dst_wb==i && i!=0.
- rsN_busy = rsN_used && rsN_id!=0 && effective count(rsN_id) > 0. Effective count is defined under Optional Feature.
- waw_full = issue_wr && issue_rd!=0 && count(issue_rd)==2^CNT_W-1 && !wb_hit(issue_rd).
- stall_id = issue_valid && (rs1_busy || rs2_busy || waw_full) && !flush.
- Issue is accepted when issue_valid && !stall_id && !flush. If also issue_wr && issue_rd!=0, count(issue_rd) increments at the next edge.
- WB: wb_hit(i) decrements count(i) at the next edge.
- Simultaneous issue and WB to the same register: count unchanged.
- Underflow: WB to a register with count 0 (and no same-cycle issue) leaves count at 0 and sets wb_underflow. The flag stays set until rst.
- Flush: at the next edge all counters clear to 0; the same-cycle issue is dropped and the same-cycle WB is ignored. WBs of older instructions arriving after a flush hit count 0. These are suppressed without setting wb_underflow for 4 cycles after the flush (pipeline drain window, internal down-counter). After that window, underflow is flagged normally.
- Latency: issue to busy visible = 1 cycle. WB to busy clear = 1 cycle (0 cycles with the optional feature).
- Counter saturation never wraps; it is prevented by waw_full.

Optional Feature:
- Macro: SCB_WB_BYPASS_EN.
- Defined: effective count(i) = count(i) - wb_hit(i). A same-cycle WB clears the hazard combinationally. This is safe because the register file writes on negedge, so ID reads the new value in the same cycle.
- Undefined: effective count(i) = count(i). One extra stall cycle per RAW hazard. Used for timing-closure builds.
- busy_vec is the registered count in both builds.

Decomposition:
- Shared package holds: NUM_REGS, REG_ADDR_W=5, XZR_IDX=0, the FLUSH_DRAIN=4 constant, and the saturating-counter max function.
- Sub-module scb_entry_cnt: one per-register up/down counter with inc, dec, clr, count, nonzero and underflow outputs, instantiated NUM_REGS-1 times by generate.
- Top holds the hazard compare, stall logic, drain counter and sticky flag.

Test Plan:
- Reset: hold rst 2 cycles with random inputs → busy_vec=0, stall_id=0, wb_underflow=0.
- RAW: issue rd=5. Next cycle, issue rs1=5 with rs1_used → stall_id=1. Assert regwrite_wb, dst_wb=5 → stall_id drops in the same cycle with SCB_WB_BYPASS_EN, or one cycle later without it. busy_vec[5]=0 afterwards.
- WAW saturation (CNT_W=2): issue rd=7 three times with no WB → busy_vec[7]=1. A fourth issue to rd=7 stalls. The same fourth issue paired with a same-cycle WB to x7 is accepted, and the count stays 3.
- x0: issue rd=0, then rs1=0 → no stall, busy_vec=0. WB dst_wb=0 → no underflow.
- Flush: pending writes on x3 and x9, then assert flush with a same-cycle issue rd=4 → busy_vec=0, x4 not marked. WBs to x3 and x9 within 4 cycles → wb_underflow stays 0.
- Underflow: after the drain window, WB dst_wb=12 with count 0 → wb_underflow=1 and remains 1 until rst.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants, counter-op encoding and the saturating-counter limit helper
// for the register scoreboard (optional feature macro: SCB_WB_BYPASS_EN).
package reg_scoreboard_pkg;

  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned XZR_IDX     = 0;
  localparam int unsigned FLUSH_DRAIN = 4;
  localparam int unsigned DRAIN_W     = 3;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/scb_entry_cnt.sv
// Per-register pending-write counter: clear beats inc/dec, inc+dec cancel,
// never wraps, and flags a decrement attempted at zero.
module scb_entry_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             underflow
);
  import reg_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  cnt_op_e op;

  always_comb begin
    op = CNT_HOLD;
    if (clr)             op = CNT_CLR;
    else if (inc && !dec) op = CNT_INC;
    else if (dec && !inc) op = CNT_DEC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (op)
        CNT_CLR: count <= '0;
        CNT_INC: if (count != CNT_MAX) count <= count + CNT_W'(1);
        CNT_DEC: if (count != '0) count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign nonzero   = (count != '0);
  assign underflow = (op == CNT_DEC) && (count == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: RAW/WAW hazard detection, ID stall, flush
// drain window and sticky WB underflow flag. SCB_WB_BYPASS_EN lets a same-cycle
// WB clear a RAW hazard combinationally.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      issue_valid,
  input  logic                                      issue_wr,
  input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] rs1_id,
  input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] rs2_id,
  input  logic                                      rs1_used,
  input  logic                                      rs2_used,
  input  logic                                      regwrite_wb,
  input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] dst_wb,
  input  logic                                      flush,
  output logic                                      stall_id,
  output logic                                      rs1_busy,
  output logic                                      rs2_busy,
  output logic [NUM_REGS-1:0]                       busy_vec,
  output logic                                      wb_underflow
);
  import reg_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0]   cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] uf_vec;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] rd_sel;
  logic [NUM_REGS-1:0] eff_busy;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                waw_full;
  logic                accept;
  logic [DRAIN_W-1:0]  drain;

  // x0 has no counter; its slot is tied off so index loops stay uniform.
  assign cnt[XZR_IDX]     = '0;
  assign nonzero[XZR_IDX] = 1'b0;
  assign uf_vec[XZR_IDX]  = 1'b0;

  always_comb begin
    wb_hit = '0;
    rd_sel = '0;
    for (int unsigned i = XZR_IDX + 1; i < NUM_REGS; i++) begin
      wb_hit[i] = regwrite_wb && (dst_wb == REG_ADDR_W'(i));
      rd_sel[i] = issue_wr && (issue_rd == REG_ADDR_W'(i));
    end
  end

  always_comb begin
    eff_busy = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
`ifdef SCB_WB_BYPASS_EN
      // count - wb_hit > 0, written without a wrapping subtract
      eff_busy[i] = (cnt[i] > CNT_W'(1)) || ((cnt[i] == CNT_W'(1)) && !wb_hit[i]);
`else
      eff_busy[i] = nonzero[i];
`endif
    end
  end

  always_comb begin
    rs1_hit  = 1'b0;
    rs2_hit  = 1'b0;
    waw_full = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((rs1_id == REG_ADDR_W'(i)) && eff_busy[i]) rs1_hit = 1'b1;
      if ((rs2_id == REG_ADDR_W'(i)) && eff_busy[i]) rs2_hit = 1'b1;
      if (rd_sel[i] && (cnt[i] == CNT_MAX) && !wb_hit[i]) waw_full = 1'b1;
    end
  end

  assign rs1_busy = rs1_used && rs1_hit;
  assign rs2_busy = rs2_used && rs2_hit;
  assign stall_id = issue_valid && (rs1_busy || rs2_busy || waw_full) && !flush;
  assign accept   = issue_valid && !stall_id && !flush;

  for (genvar g = XZR_IDX + 1; g < NUM_REGS; g++) begin : g_entry
    scb_entry_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (accept && rd_sel[g]),
      .dec       (wb_hit[g] && !flush),
      .clr       (flush),
      .count     (cnt[g]),
      .nonzero   (nonzero[g]),
      .underflow (uf_vec[g])
    );
  end

  assign busy_vec = nonzero;

  // Late WBs from flushed-out older instructions land on cleared counters.
  always_ff @(posedge clk) begin
    if (rst)                drain <= '0;
    else if (flush)         drain <= DRAIN_W'(FLUSH_DRAIN);
    else if (drain != '0)   drain <= drain - DRAIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                              wb_underflow <= 1'b0;
    else if ((|uf_vec) && (drain == '0))  wb_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard; post-edge state expectations flow
// through a scoreboard queue. Honours SCB_WB_BYPASS_EN for bypass timing.
module tb_reg_scoreboard;

`ifdef SCB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr, rs1_used, rs2_used, regwrite_wb, flush;
  logic [4:0]  issue_rd, rs1_id, rs2_id, dst_wb;
  logic        stall_id, rs1_busy, rs2_busy, wb_underflow;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .regwrite_wb  (regwrite_wb),
    .dst_wb       (dst_wb),
    .flush        (flush),
    .stall_id     (stall_id),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .busy_vec     (busy_vec),
    .wb_underflow (wb_underflow)
  );

  typedef struct {
    logic       iv, iw;
    logic [4:0] rd, rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2, wb;
    logic [4:0] dwb;
    logic       fl;
    logic       e_stall, e_r1, e_r2;
    logic [31:0] e_busy;
    logic       e_uf;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic        uf;
    int          row;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic logic [31:0] b(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(input logic iv, iw, input logic [4:0] rd, rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, wb, input logic [4:0] dwb,
                              input logic fl, es, er1, er2, input logic [31:0] eb, input logic euf);
    vec_t v;
    v.iv = iv; v.iw = iw; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.wb = wb; v.dwb = dwb; v.fl = fl;
    v.e_stall = es; v.e_r1 = er1; v.e_r2 = er2; v.e_busy = eb; v.e_uf = euf;
    return v;
  endfunction

  task automatic check(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_wr = v.iw; issue_rd = v.rd;
    rs1_id = v.rs1; rs1_used = v.u1; rs2_id = v.rs2; rs2_used = v.u2;
    regwrite_wb = v.wb; dst_wb = v.dwb; flush = v.fl;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 32'd0,0));
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check("stall_id", row, 32'(stall_id), 32'(v.e_stall));
    check("rs1_busy", row, 32'(rs1_busy), 32'(v.e_r1));
    check("rs2_busy", row, 32'(rs2_busy), 32'(v.e_r2));
    exp_q.push_back('{busy: v.e_busy, uf: v.e_uf, row: row});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("busy_vec", e.row, busy_vec, e.busy);
    check("wb_underflow", e.row, 32'(wb_underflow), 32'(e.uf));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // reset held two cycles under random stimulus
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      issue_valid = 1'($urandom); issue_wr = 1'($urandom); issue_rd = 5'($urandom);
      rs1_id = 5'($urandom); rs2_id = 5'($urandom); rs1_used = 1'($urandom); rs2_used = 1'($urandom);
      regwrite_wb = 1'($urandom); dst_wb = 5'($urandom); flush = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("reset busy_vec", 0, busy_vec, 32'd0);
    check("reset wb_underflow", 0, 32'(wb_underflow), 32'd0);
    check("reset stall_id", 0, 32'(stall_id), 32'd0);

    //         iv iw rd  rs1 u1 rs2 u2 wb dwb fl  stall  r1    r2    busy          uf
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  0,0,  0,  0,    0,    0,    32'd0,        0)); // 1 idle
    vecs.push_back(mk(1,1,5,  0,0,  0,0,  0,0,  0,  0,    0,    0,    b(5),         0)); // 2 issue rd5
    vecs.push_back(mk(1,0,0,  5,1,  0,0,  0,0,  0,  1,    1,    0,    b(5),         0)); // 3 RAW stall
    vecs.push_back(mk(1,0,0,  5,1,  0,0,  1,5,  0,  !BYP, !BYP, 0,    32'd0,        0)); // 4 WB same cycle
    vecs.push_back(mk(1,0,0,  5,1,  0,0,  0,0,  0,  0,    0,    0,    32'd0,        0)); // 5 cleared
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0,  0,    0,    0,    b(7),         0)); // 6 rd7 #1
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0,  0,    0,    0,    b(7),         0)); // 7 rd7 #2
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0,  0,    0,    0,    b(7),         0)); // 8 rd7 #3
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0,  1,    0,    0,    b(7),         0)); // 9 WAW full
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  1,7,  0,  0,    0,    0,    b(7),         0)); // 10 full + WB
    vecs.push_back(mk(1,1,7,  0,0,  0,0,  0,0,  0,  1,    0,    0,    b(7),         0)); // 11 still 3
    vecs.push_back(mk(1,0,0,  0,0,  7,1,  1,7,  0,  1,    0,    1,    b(7),         0)); // 12 rs2, cnt 3
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,7,  0,  0,    0,    0,    b(7),         0)); // 13 cnt 1
    vecs.push_back(mk(1,0,0,  0,0,  7,1,  1,7,  0,  !BYP, 0,    !BYP, 32'd0,        0)); // 14 last WB
    vecs.push_back(mk(1,1,0,  0,0,  0,0,  0,0,  0,  0,    0,    0,    32'd0,        0)); // 15 rd x0
    vecs.push_back(mk(1,0,0,  0,1,  0,1,  0,0,  0,  0,    0,    0,    32'd0,        0)); // 16 rs x0
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,0,  0,  0,    0,    0,    32'd0,        0)); // 17 WB x0
    vecs.push_back(mk(1,1,3,  0,0,  0,0,  0,0,  0,  0,    0,    0,    b(3),         0)); // 18 rd3
    vecs.push_back(mk(1,1,9,  5,0,  3,0,  0,0,  0,  0,    0,    0,    b(3)|b(9),    0)); // 19 rd9, unused rs
    vecs.push_back(mk(1,1,4,  3,1,  0,0,  0,0,  1,  0,    1,    0,    32'd0,        0)); // 20 flush
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,3,  0,  0,    0,    0,    32'd0,        0)); // 21 drain 4
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,9,  0,  0,    0,    0,    32'd0,        0)); // 22 drain 3
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  0,0,  0,  0,    0,    0,    32'd0,        0)); // 23 drain 2
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,3,  0,  0,    0,    0,    32'd0,        0)); // 24 drain 1
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  1,12, 0,  0,    0,    0,    32'd0,        1)); // 25 underflow
    vecs.push_back(mk(0,0,0,  0,0,  0,0,  0,0,  0,  0,    0,    0,    32'd0,        1)); // 26 sticky
    vecs.push_back(mk(1,1,20, 0,0,  0,0,  0,0,  0,  0,    0,    0,    b(20),        1)); // 27 rd20

    foreach (vecs[k]) apply(vecs[k], k + 1);

    // reset mid-operation: pending x20 and sticky flag both discarded
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check("midreset busy_vec", 100, busy_vec, 32'd0);
    check("midreset wb_underflow", 100, 32'(wb_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b1; rs1_id = 5'd20; rs1_used = 1'b1;
    #1;
    check("midreset stall_id", 101, 32'(stall_id), 32'd0);
    check("midreset rs1_busy", 101, 32'(rs1_busy), 32'd0);
    @(negedge clk);
    idle();
    regwrite_wb = 1'b1; dst_wb = 5'd20;
    @(posedge clk);
    #1;
    check("post-reset underflow", 102, 32'(wb_underflow), 32'd1);
    @(negedge clk);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
